// File: rtl/rnn_matvec_if.sv
// Handshake and tensor-port bundle between the mat-vec sequencer and its environment.
interface rnn_matvec_if #(
    parameter int DW = 16,
    parameter int RW = 4,
    parameter int CW = 4
);
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic [CW-1:0] v_sel;
    logic [RW-1:0] b_sel;
    logic [DW-1:0] w_data;
    logic [DW-1:0] v_data;
    logic [DW-1:0] b_data;
    logic          res_write;
    logic [RW-1:0] res_sel;
    logic [DW-1:0] res_data;

    modport master (
        input  start, abort, w_data, v_data, b_data,
        output busy, done, w_row, w_col, v_sel, b_sel, res_write, res_sel, res_data
    );

    modport slave (
        output start, abort, w_data, v_data, b_data,
        input  busy, done, w_row, w_col, v_sel, b_sel, res_write, res_sel, res_data
    );
endinterface

// File: rtl/rnn_matvec_ctrl.sv
// Recurrent mat-vec sequencer: res[i] = sum_j W[i][j]*v[j] + b[i], signed fixed point.
// Define RNN_MATVEC_SAT_EN to saturate results instead of two's-complement wrap.
module rnn_matvec_ctrl #(
    parameter int ROWS = 16,
    parameter int COLS = 16,
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int RW   = 4,
    parameter int CW   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rnn_matvec_if.master mv
);
    localparam int PW = 2 * DW;
    localparam int AW = 2 * DW + $clog2(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACC, S_WB, S_DONE} state_t;

    state_t               state, state_nx;
    logic [RW-1:0]        row, row_nx;
    logic [CW-1:0]        col, col_nx;
    logic signed [AW-1:0] acc, acc_nx;
    logic signed [PW-1:0] w_ext, v_ext, prod;
    logic [DW-1:0]        res_val;

    assign w_ext = PW'($signed(mv.w_data));
    assign v_ext = PW'($signed(mv.v_data));
    assign prod  = w_ext * v_ext;

`ifdef RNN_MATVEC_SAT_EN
    localparam int SW = AW + 1;
    localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    logic signed [SW-1:0] sum;

    assign sum = SW'(acc >>> FRAC) + SW'($signed(mv.b_data));

    always_comb begin
        if (sum > MAXV)
            res_val = {1'b0, {(DW-1){1'b1}}};
        else if (sum < MINV)
            res_val = {1'b1, {(DW-1){1'b0}}};
        else
            res_val = sum[DW-1:0];
    end
`else
    // Only the low DW bits of the sum survive the wrap, so add at DW width directly.
    always_comb begin
        res_val = DW'(acc >>> FRAC) + mv.b_data;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            row   <= '0;
            col   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            row   <= row_nx;
            col   <= col_nx;
            acc   <= acc_nx;
        end
    end

    // Read data lags the select by one cycle, so the first MAC cycle of a row has nothing to add.
    always_comb begin
        state_nx = state;
        row_nx   = row;
        col_nx   = col;
        acc_nx   = acc;
        case (state)
            S_IDLE: begin
                if (mv.start && !mv.abort) begin
                    state_nx = S_MAC;
                    row_nx   = '0;
                    col_nx   = '0;
                    acc_nx   = '0;
                end
            end
            S_MAC: begin
                if (mv.abort) begin
                    state_nx = S_IDLE;
                end else begin
                    if (col != '0)
                        acc_nx = acc + AW'(prod);
                    if (col == COL_LAST)
                        state_nx = S_ACC;
                    else
                        col_nx = col + 1'b1;
                end
            end
            S_ACC: begin
                if (mv.abort) begin
                    state_nx = S_IDLE;
                end else begin
                    acc_nx   = acc + AW'(prod);
                    state_nx = S_WB;
                end
            end
            S_WB: begin
                if (mv.abort) begin
                    state_nx = S_IDLE;
                end else if (row == ROW_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_MAC;
                    row_nx   = row + 1'b1;
                    col_nx   = '0;
                    acc_nx   = '0;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mv.busy      = (state != S_IDLE);
        mv.done      = (state == S_DONE) && !mv.abort;
        mv.res_write = (state == S_WB) && !mv.abort;
        mv.res_sel   = row;
        mv.res_data  = (state == S_WB) ? res_val : '0;
        mv.w_row     = row;
        mv.b_sel     = row;
        mv.w_col     = col;
        mv.v_sel     = col;
    end
endmodule
